// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage among N requesters.
// Each grant lasts up to MAX_BURST beats; output beats are tagged with their source index.
module stream_rr_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned SW       = (N > 2) ? $clog2(N) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [N*WIDTH-1:0] i_in_data,
  input  logic [N-1:0]       i_in_valid,
  output logic [N-1:0]       o_in_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [SW-1:0]      o_out_src,
  output logic [N-1:0]       o_grant
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;
  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    g_q, g_d;
  logic [SW-1:0]    p_q, p_d;
  logic [7:0]       c_q, c_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    src_q, src_d;

  logic             granted, load, g_valid, xfer, rel, any_valid;
  logic [SW-1:0]    pick, idx;
  logic [WIDTH-1:0] sel_data;

  assign granted = (state_q == StGrant);
  assign load    = !valid_q || i_out_ready;
  assign g_valid = i_in_valid[g_q];
  assign xfer    = granted && g_valid && i_enable && load;
  assign rel     = granted && ((xfer && (c_q + 8'd1 == MaxBurst)) || !g_valid || !i_enable);

  // First valid requester scanning upward from the rotation pointer, with wrap.
  always_comb begin
    pick      = p_q;
    idx       = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = SW'((32'(p_q) + i) % N);
      if (!any_valid && i_in_valid[idx]) begin
        pick      = idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (g_q == SW'(k)) sel_data = i_in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_in_ready = '0;
    if (granted && i_enable && load) o_in_ready[g_q] = 1'b1;
  end

  assign o_grant     = granted ? (N'(1) << g_q) : '0;
  assign o_out_data  = data_q;
  assign o_out_valid = valid_q;
  assign o_out_src   = src_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    c_d     = c_q;
    data_d  = data_q;
    src_d   = src_q;
    // The output stage drains whenever it may load; a transfer refills it.
    valid_d = load ? xfer : valid_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable && any_valid) begin
          g_d     = pick;
          c_d     = 8'd0;
          state_d = StGrant;
        end
      end
      default: begin
        if (xfer) begin
          data_d = sel_data;
          src_d  = g_q;
          c_d    = c_q + 8'd1;
        end
        if (rel) begin
          state_d = StIdle;
          p_d     = (g_q == SW'(N - 1)) ? '0 : g_q + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      p_q     <= '0;
      c_q     <= 8'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      c_q     <= c_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic, each cycle checked
// against a queue-based reference model; a second instance covers MAX_BURST=1 with N=2.
module tb_stream_rr_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned MB = 8;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst, en, out_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready, grant;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;

  logic        rst2, en2, out_valid2, out_ready2;
  logic [31:0] in_data2;
  logic [1:0]  in_valid2, in_ready2, grant2;
  logic [15:0] out_data2;
  logic [0:0]  out_src2;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_src(out_src), .o_grant(grant)
  );

  stream_rr_arbiter #(.WIDTH(16), .N(2), .MAX_BURST(1)) dut2 (
    .i_clock(clk), .i_reset(rst2), .i_enable(en2),
    .i_in_data(in_data2), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
    .o_out_data(out_data2), .o_out_valid(out_valid2), .i_out_ready(out_ready2),
    .o_out_src(out_src2), .o_grant(grant2)
  );

  typedef logic [W-1:0] beat_q_t [$];
  beat_q_t srcq [N];
  logic [SW+W-1:0] obs_log [$];
  int              grant_log [$];

  // Reference model: current grant (-1 when idle), pointer, beats in grant, output stage.
  int           m_g, m_p, m_c, m_os;
  logic         m_ov;
  logic [W-1:0] m_od;

  logic [N-1:0] src_en, prev_grant;
  logic         drv_en, drv_ready, drv_rst;
  int           n_assert = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW+W-1:0] obs_at(input int j);
    if (j < obs_log.size()) return obs_log[j];
    return 'x;
  endfunction

  function automatic int grant_at(input int j);
    if (j < grant_log.size()) return grant_log[j];
    return -1;
  endfunction

  task automatic push(input int k, input int count);
    for (int i = 0; i < count; i++) srcq[k].push_back(W'((k << 12) | i));
  endtask

  task automatic clear_logs();
    obs_log.delete();
    grant_log.delete();
  endtask

  task automatic cycle();
    logic [N-1:0] vmask, exp_rdy;
    logic         load, xfer, rel;
    int           pick;
    vmask = '0;
    for (int k = 0; k < N; k++) begin
      if (src_en[k] && srcq[k].size() > 0) begin
        vmask[k] = 1'b1;
        in_data[k*W +: W] = srcq[k][0];
      end else begin
        in_data[k*W +: W] = W'($urandom);
      end
    end
    in_valid  = vmask;
    en        = drv_en;
    out_ready = drv_ready;
    rst       = drv_rst;
    #1;
    load    = !m_ov || drv_ready;
    exp_rdy = '0;
    if (m_g >= 0 && drv_en && load) exp_rdy[m_g] = 1'b1;
    chk("grant", grant, (m_g >= 0) ? (64'd1 << m_g) : 64'd0);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_src", out_src, m_os);
    if (!drv_rst && out_valid && drv_ready) obs_log.push_back({out_src, out_data});
    if (grant != '0 && prev_grant == '0)
      for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
    prev_grant = grant;
    if (drv_rst) begin
      m_g = -1; m_p = 0; m_c = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
    end else if (m_g < 0) begin
      if (m_ov && drv_ready) m_ov = 1'b0;
      if (drv_en && vmask != '0) begin
        pick = m_p;
        for (int i = N - 1; i >= 0; i--) if (vmask[(m_p + i) % N]) pick = (m_p + i) % N;
        m_g = pick;
        m_c = 0;
      end
    end else begin
      xfer = vmask[m_g] && drv_en && load;
      if (xfer) begin
        m_od = srcq[m_g].pop_front();
        m_os = m_g;
        m_ov = 1'b1;
        m_c++;
      end else if (load) begin
        m_ov = 1'b0;
      end
      rel = (xfer && m_c == MB) || !vmask[m_g] || !drv_en;
      if (rel) begin
        m_p = (m_g + 1) % N;
        m_g = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    rst2 = 1'b1; en2 = 1'b0; in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b1;
    src_en = '0; drv_en = 1'b1; drv_ready = 1'b1; drv_rst = 1'b0; prev_grant = '0;
    m_g = -1; m_p = 0; m_c = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_grant", grant, 0);
    run(2);

    // Single source: three beats from requester 2.
    srcq[2].push_back(16'h0001); srcq[2].push_back(16'h0002); srcq[2].push_back(16'h0003);
    src_en = 4'b0100;
    clear_logs();
    run(8);
    chk("t1_count", obs_log.size(), 3);
    for (int j = 0; j < 3; j++) chk("t1_beat", obs_at(j), {2'd2, 16'(j + 1)});
    chk("t1_grant_idle", grant, 0);

    // All busy: pointer left at 3, so service runs 3,0,1,2,3,0,1,2 in bursts of 8.
    for (int k = 0; k < N; k++) push(k, 16);
    src_en = 4'b1111;
    clear_logs();
    run(82);
    chk("t2_grants", grant_log.size(), 8);
    for (int r = 0; r < 8; r++) chk("t2_order", grant_at(r), (3 + r) % 4);
    chk("t2_beats", obs_log.size(), 64);
    for (int j = 0; j < 64; j++) begin
      int s, i;
      s = (3 + j / 8) % 4;
      i = ((j / 8) / 4) * 8 + j % 8;
      chk("t2_beat", obs_at(j), {2'(s), W'((s << 12) | i)});
    end

    // Backpressure during a burst from requester 1.
    src_en = 4'b0010;
    push(1, 10);
    clear_logs();
    run(4);
    drv_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("t3_hold_data", out_data, 16'h1002);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_ready", in_ready, 0);
    end
    drv_ready = 1'b1;
    run(15);
    chk("t3_count", obs_log.size(), 10);
    for (int j = 0; j < 10; j++) chk("t3_beat", obs_at(j), {2'd1, 16'h1000 + 16'(j)});

    // Enable gating after three beats of requester 3.
    src_en = 4'b1010;
    push(3, 10);
    push(1, 10);
    clear_logs();
    run(4);
    drv_en = 1'b0;
    cycle();
    chk("t4_released", grant, 0);
    repeat (3) begin
      cycle();
      chk("t4_no_grant", grant, 0);
    end
    chk("t4_drained", obs_log.size(), 3);
    drv_en = 1'b1;
    run(40);
    chk("t4_first", grant_at(0), 3);
    chk("t4_next", grant_at(1), 1);
    for (int j = 0; j < 3; j++) chk("t4_beat", obs_at(j), {2'd3, 16'h3000 + 16'(j)});
    chk("t4_resume", obs_at(3), {2'd1, 16'h1000});

    // Reset during the fourth beat of requester 3.
    src_en = 4'b1001;
    push(3, 10);
    push(0, 10);
    clear_logs();
    run(4);
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_src", out_src, 0);
    chk("t5_grant", grant, 0);
    chk("t5_ready", in_ready, 0);
    clear_logs();
    run(40);
    chk("t5_first", grant_at(0), 0);
    chk("t5_count", obs_log.size(), 17);
    chk("t5_beat0", obs_at(0), {2'd0, 16'h0000});
    chk("t5_represent", obs_at(8), {2'd3, 16'h3003});

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) src_en = N'($urandom);
      drv_en    = ($urandom_range(0, 9) != 0);
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_rst   = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++)
        if (srcq[k].size() < 4 && $urandom_range(0, 1) == 1) srcq[k].push_back(W'($urandom));
      cycle();
    end
    drv_rst = 1'b0; drv_en = 1'b1; drv_ready = 1'b1; src_en = 4'b1111;
    run(120);
    chk("drain_valid", out_valid, 0);
    chk("drain_grant", grant, 0);

    // MAX_BURST=1, N=2, both always valid: grants alternate with single bubbles.
    rst2 = 1'b0; en2 = 1'b1; in_valid2 = 2'b11; in_data2 = {16'hA001, 16'hA000};
    out_ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("mb1_grant", grant2, (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10));
      chk("mb1_valid", out_valid2, i % 2);
      if (i % 2 == 1) begin
        chk("mb1_src", out_src2, (i / 2) % 2);
        chk("mb1_data", out_data2, 16'hA000 + 16'((i / 2) % 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
